// File: rtl/mux_stream_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package muxs_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a binary index able to address n items (minimum 1 bit).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_stream_rr_if.sv
// Stream bundle for mux_stream_rr: N_CH input channels and one output channel.
// in_last/out_last exist only when MUXS_PKT_LOCK_EN is defined.
interface mux_stream_rr_if
  import muxs_pkg::*;
#(
  parameter int N_CH      = 5,
  parameter int BIT_WIDTH = 8
) ();

  localparam int SEL_W = clog2(N_CH);

  logic [N_CH-1:0]           in_valid;
  logic [N_CH*BIT_WIDTH-1:0] in_data;
  logic [N_CH-1:0]           in_ready;
  logic                      out_valid;
  logic [BIT_WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;
`ifdef MUXS_PKT_LOCK_EN
  logic [N_CH-1:0]           in_last;
  logic                      out_last;

  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_sel, out_last);
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_sel, out_last);
`else
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
`endif

endinterface

// File: rtl/mux_stream_rr_arbiter.sv
// Round-robin / fixed-priority arbiter with an optional grant lock.
// Grant is purely combinational; rr_ptr advances only when told to.
module mux_rr_arbiter
  import muxs_pkg::*;
#(
  parameter int N_CH     = 5,
  parameter int ARB_MODE = ARB_RR,
  localparam int SEL_W   = clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req_i,
  input  logic             advance_i,
  input  logic             lock_i,
  input  logic [SEL_W-1:0] lock_idx_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [SEL_W-1:0] grant_idx_o
);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    if (lock_i) begin
      if (req_i[lock_idx_i]) begin
        grant_o[lock_idx_i] = 1'b1;
        grant_idx_o         = lock_idx_i;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        int idx;
        idx = (ARB_MODE == ARB_FIXED) ? k : int'(rr_ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          grant_o[idx] = 1'b1;
          grant_idx_o  = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == ARB_RR && advance_i)
      rr_ptr_d = (grant_idx_o == SEL_W'(N_CH - 1)) ? '0 : grant_idx_o + 1'b1;
  end

  // NOTE: asynchronous active-low reset lives in the sensitivity list; release is synchronised upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Define MUXS_PKT_LOCK_EN to hold the grant on a channel until its last beat.
module mux_stream_rr
  import muxs_pkg::*;
#(
  parameter int N_CH      = 5,
  parameter int BIT_WIDTH = 8,
  parameter int ARB_MODE  = ARB_RR,
  localparam int SEL_W    = clog2(N_CH)
) (
  input logic            clk,
  input logic            rst,
  mux_stream_rr_if.slave bus_if
);

  logic                 load, xfer, advance, sel_last, lock, out_valid_q, out_valid_d;
  logic [N_CH-1:0]      grant;
  logic [SEL_W-1:0]     grant_idx, lock_idx, out_sel_q, out_sel_d;
  logic [BIT_WIDTH-1:0] sel_data, out_data_q, out_data_d;

  // The output register can take a beat when it is empty or being drained this cycle.
  assign load            = !out_valid_q || bus_if.out_ready;
  assign bus_if.in_ready = (rst && load) ? grant : '0;
  assign xfer            = |(bus_if.in_ready & bus_if.in_valid);
  assign advance         = xfer && sel_last;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_data = bus_if.in_data[i*BIT_WIDTH +: BIT_WIDTH];
`ifdef MUXS_PKT_LOCK_EN
        sel_last = bus_if.in_last[i];
`endif
      end
    end
  end

  mux_rr_arbiter #(.N_CH(N_CH), .ARB_MODE(ARB_MODE)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (bus_if.in_valid),
    .advance_i   (advance),
    .lock_i      (lock),
    .lock_idx_i  (lock_idx),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_sel_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_sel   = out_sel_q;

`ifdef MUXS_PKT_LOCK_EN
  logic             lock_q, lock_d, out_last_q, out_last_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;

  // A non-last beat locks the grant to its channel; the last beat releases it.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    out_last_d = out_last_q;
    if (xfer) begin
      lock_d     = !sel_last;
      lock_idx_d = grant_idx;
      out_last_d = sel_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign lock            = lock_q;
  assign lock_idx        = lock_idx_q;
  assign bus_if.out_last = out_last_q;
`else
  assign lock     = 1'b0;
  assign lock_idx = '0;
`endif

endmodule
